// File: rtl/prog_feeder.sv
// Program feeder: buffers a short 6-bit program, then replays it into a CPU after a reset pulse.
// Optional macro PROG_FEEDER_LOOP_EN makes the program loop instead of halting at its end.
module prog_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [5:0] load_data,
    output logic       load_ready,
    input  logic       load_clear,
    input  logic       run,
    input  logic       pc_valid,
    input  logic [7:0] pc_in,
    output logic       cpu_rst,
    output logic [5:0] instr_out,
    output logic       instr_valid,
    output logic       halted
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_e;

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fe_ptr_q, fe_ptr_d;
    logic [5:0]    mem [DEPTH];
    logic [5:0]    instr_q;
    logic          load_fire;
    logic          fetch;
    logic [AW:0]   fe_next;
    logic          unused_pc_hi;

    assign unused_pc_hi = ^pc_in[7:AW];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        fe_ptr_d   = fe_ptr_q;
        load_ready = 1'b0;
        load_fire  = 1'b0;
        fetch      = 1'b0;
        // One bit wider than the pointer so running off the end of a full program is visible.
        fe_next    = pc_valid ? {1'b0, pc_in[AW-1:0]} : {1'b0, fe_ptr_q} + 1'b1;
        case (state_q)
            IDLE: begin
                load_ready = (len_q != LEN_FULL);
                if (load_clear) begin
                    len_d    = '0;
                    wr_ptr_d = '0;
                end else if (load_valid && load_ready) begin
                    load_fire = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    len_d     = len_q + 1'b1;
                end
                if (run && (len_d != '0)) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                fe_ptr_d = '0;
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                    fetch   = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (fe_next >= len_q) begin
`ifdef PROG_FEEDER_LOOP_EN
                    if (pc_valid) begin
                        state_d = HALT;
                    end else begin
                        fe_ptr_d = '0;
                        fetch    = 1'b1;
                    end
`else
                    state_d = HALT;
`endif
                end else begin
                    fe_ptr_d = fe_next[AW-1:0];
                    fetch    = 1'b1;
                end
            end
            HALT: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_ptr_q <= '0;
            fe_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            fe_ptr_q <= fe_ptr_d;
        end
    end

    // Storage is never reset; the write is blocked while reset is held so an aborted load leaves no trace.
    always_ff @(posedge clk) begin
        if (load_fire && rst) begin
            mem[wr_ptr_q] <= load_data;
        end
        if (fetch) begin
            instr_q <= mem[fe_ptr_d];
        end
    end

    assign cpu_rst     = (state_q == PRIME);
    assign instr_valid = (state_q == RUN);
    assign instr_out   = instr_valid ? instr_q : 6'b000000;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_prog_feeder.sv
// Self-checking bench for prog_feeder: directed scenarios plus randomized programs and branches
// compared against a program-level reference model.
module tb_prog_feeder;

    localparam int DEPTH = 16;

    logic       clk, rst;
    logic       load_valid, load_clear, run, pc_valid;
    logic [5:0] load_data;
    logic [7:0] pc_in;
    logic       load_ready, cpu_rst, instr_valid, halted;
    logic [5:0] instr_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0] mmem [DEPTH];
    int         mlen = 0;
    int         mwr  = 0;

    prog_feeder #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_clear(load_clear), .run(run), .pc_valid(pc_valid), .pc_in(pc_in),
        .cpu_rst(cpu_rst), .instr_out(instr_out), .instr_valid(instr_valid), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [5:0] d);
        check("ld_ready", load_ready, (mlen != DEPTH));
        load_valid = 1'b1;
        load_data  = d;
        if (mlen < DEPTH) begin
            mmem[mwr] = d;
            mwr  = (mwr + 1) % DEPTH;
            mlen = mlen + 1;
        end
        tick();
        load_valid = 1'b0;
    endtask

    task automatic clear_prog();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
        mlen = 0;
        mwr  = 0;
    endtask

    // Executes the stored program: br_cycle (1-based RUN cycle) forces a branch to br_pc;
    // rnd adds random branches. The model tracks the executing word index p.
    task automatic run_prog(input int br_cycle, input logic [7:0] br_pc, input bit rnd, input int max_cyc);
        int p;
        int t;
        int hi;
        bit h;
        logic [7:0] pc;
        p = 0;
        h = 0;
        run = 1'b1;
        tick();
        check("prime_cpu_rst", cpu_rst, 1'b1);
        check("prime_vld", instr_valid, 1'b0);
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (h) begin
                check("halt_flag", halted, 1'b1);
                check("halt_vld", instr_valid, 1'b0);
                check("halt_out", instr_out, 6'h00);
                break;
            end
            check("run_vld", instr_valid, 1'b1);
            check("run_out", instr_out, mmem[p]);
            check("run_halted", halted, 1'b0);
            check("run_cpu_rst", cpu_rst, 1'b0);
            check("run_ld_ready", load_ready, 1'b0);
            pc_valid = 1'b0;
            if (c == br_cycle || (rnd && $urandom_range(0, 3) == 0)) begin
                hi = (mlen + 1 > 15) ? 15 : mlen + 1;
                pc = (c == br_cycle) ? br_pc : {4'($urandom_range(0, 15)), 4'($urandom_range(0, hi))};
                pc_valid = 1'b1;
                pc_in = pc;
                t = pc % DEPTH;
                if (t >= mlen) h = 1;
                else p = t;
            end else begin
                p = p + 1;
                if (p >= mlen) begin
`ifdef PROG_FEEDER_LOOP_EN
                    p = 0;
`else
                    h = 1;
`endif
                end
            end
        end
        pc_valid = 1'b0;
        if (h) begin
            tick();
            check("halt_persist", halted, 1'b1);
        end
        run = 1'b0;
        tick();
        check("idle_halted", halted, 1'b0);
        check("idle_vld", instr_valid, 1'b0);
        check("idle_ld_ready", load_ready, (mlen != DEPTH));
    endtask

    initial begin
        rst = 1'b0;
        load_valid = 1'b0; load_clear = 1'b0; run = 1'b0; pc_valid = 1'b0;
        load_data = '0; pc_in = '0;
        #2;
        check("rst_ld_ready", load_ready, 1'b1);
        check("rst_cpu_rst", cpu_rst, 1'b0);
        check("rst_vld", instr_valid, 1'b0);
        check("rst_out", instr_out, 6'h00);
        check("rst_halted", halted, 1'b0);
        #20;
        rst = 1'b1;
        tick();

        // Three-word program runs straight through to HALT
        load_word(6'h01); load_word(6'h12); load_word(6'h23);
        run_prog(0, 8'h00, 1'b0, 30);

        // Full buffer: 17th word refused, length stays 16
        clear_prog();
        for (int i = 0; i < DEPTH; i++) load_word(6'($urandom_range(0, 63)));
        check("full_ld_ready", load_ready, 1'b0);
        load_word(6'h3F);
        check("full_ld_ready2", load_ready, 1'b0);
        run_prog(0, 8'h00, 1'b0, 40);

        // Branch back to word 2 on the 4th RUN cycle, then out-of-range branch
        clear_prog();
        for (int i = 0; i < 5; i++) load_word(6'(8'h30 + i));
        run_prog(4, 8'h02, 1'b0, 30);
        run_prog(2, 8'h09, 1'b0, 30);
        run_prog(0, 8'h00, 1'b0, 30);

        // Dropping run during PRIME returns to IDLE
        run = 1'b1;
        tick();
        check("prime2_cpu_rst", cpu_rst, 1'b1);
        run = 1'b0;
        tick();
        check("abort_cpu_rst", cpu_rst, 1'b0);
        check("abort_vld", instr_valid, 1'b0);
        tick();
        check("abort_idle_vld", instr_valid, 1'b0);

        // Clear wins over a simultaneous load; run with empty program stays idle
        load_clear = 1'b1; load_valid = 1'b1; load_data = 6'h15;
        tick();
        load_clear = 1'b0; load_valid = 1'b0;
        mlen = 0; mwr = 0;
        run = 1'b1;
        tick();
        check("empty_cpu_rst", cpu_rst, 1'b0);
        tick();
        check("empty_vld", instr_valid, 1'b0);
        run = 1'b0;

`ifdef PROG_FEEDER_LOOP_EN
        clear_prog();
        load_word(6'h0A); load_word(6'h0B);
        run_prog(0, 8'h00, 1'b0, 8);
`endif

        // Randomized programs with random branches
        for (int r = 0; r < 12; r++) begin
            clear_prog();
            for (int i = 0; i < $urandom_range(1, DEPTH); i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                load_word(6'($urandom_range(0, 63)));
            end
            run_prog(0, 8'h00, 1'b1, 60);
        end

        // Asynchronous reset in the middle of a run
        clear_prog();
        for (int i = 0; i < 4; i++) load_word(6'(8'h20 + i));
        run = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_vld", instr_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_vld", instr_valid, 1'b0);
        check("async_out", instr_out, 6'h00);
        check("async_cpu_rst", cpu_rst, 1'b0);
        check("async_halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mlen = 0; mwr = 0;
        tick();
        check("post_rst_cpu_rst", cpu_rst, 1'b0);
        check("post_rst_ld_ready", load_ready, 1'b1);
        tick();
        check("post_rst_vld", instr_valid, 1'b0);
        run = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
